// File: rtl/systolic_scheduler.sv
// Sequencing controller for systolic_array: packs job operand pairs into lane batches,
// fires the array with an active-lane mask, then streams the captured products in lane order.
module systolic_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS  = 16,
    parameter int LEN_W      = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            job_valid,
    input  logic [LEN_W-1:0]                job_len,
    output logic                            job_ready,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH-1:0]           in_a,
    input  logic [DATA_WIDTH-1:0]           in_b,
    output logic                            in_ready,
    output logic                            arr_start,
    output logic [NUM_UNITS-1:0]            arr_active,
    output logic [NUM_UNITS*DATA_WIDTH-1:0] arr_a,
    output logic [NUM_UNITS*DATA_WIDTH-1:0] arr_b,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] arr_result,
    input  logic [NUM_UNITS-1:0]            arr_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic                            done,
    output logic                            err_timeout
);

    localparam int LANE_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DRAIN} state_t;
    typedef logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] lanes_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [LANE_W-1:0]   last_q, last_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    lanes_t              a_q, a_d, b_q, b_d, res_q, res_d;
    logic [NUM_UNITS-1:0] active_q, active_d;
    logic                done_q, done_d, err_q, err_d;

    // Index of the final lane in a batch: min(NUM_UNITS, n) - 1, with n > 0.
    function automatic logic [LANE_W-1:0] batch_last(input logic [LEN_W-1:0] n);
        if (n >= LEN_W'(NUM_UNITS)) return LANE_W'(NUM_UNITS - 1);
        return LANE_W'(n - LEN_W'(1));
    endfunction

    function automatic logic [NUM_UNITS-1:0] lane_mask(input logic [LANE_W-1:0] last);
        logic [NUM_UNITS-1:0] m;
        for (int i = 0; i < NUM_UNITS; i++) m[i] = (i <= int'(last));
        return m;
    endfunction

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        last_d      = last_q;
        lane_d      = lane_q;
        wait_d      = wait_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        active_d    = active_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        job_ready   = 1'b0;
        in_ready    = 1'b0;
        arr_start   = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;

        case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                lane_d    = '0;
                wait_d    = '0;
                if (job_valid) begin
                    if (job_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d = job_len;
                        last_d      = batch_last(job_len);
                        state_d     = FILL;
                    end
                end
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d[lane_q] = in_a;
                    b_d[lane_q] = in_b;
                    if (lane_q == last_q) begin
                        lane_d      = '0;
                        remaining_d = remaining_q - LEN_W'(last_q) - LEN_W'(1);
                        active_d    = lane_mask(last_q);
                        state_d     = ISSUE;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            ISSUE: begin
                arr_start = 1'b1;
                wait_d    = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // Ready seen in the first WAIT cycle may still belong to the previous batch.
                if (wait_q != '0 && (arr_ready & active_q) == active_q) begin
                    res_d   = arr_result;
                    state_d = DRAIN;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    err_d       = 1'b1;
                    remaining_d = '0;
                    active_d    = '0;
                    a_d         = '0;
                    b_d         = '0;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = res_q[lane_q];
                out_last  = (lane_q == last_q) && (remaining_q == '0);
                if (out_ready) begin
                    if (lane_q == last_q) begin
                        lane_d   = '0;
                        active_d = '0;
                        a_d      = '0;
                        b_d      = '0;
                        if (remaining_q != '0) begin
                            last_d  = batch_last(remaining_q);
                            state_d = FILL;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            last_q      <= '0;
            lane_q      <= '0;
            wait_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            active_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            last_q      <= last_d;
            lane_q      <= lane_d;
            wait_q      <= wait_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            active_q    <= active_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign arr_active  = active_q;
    assign arr_a       = a_q;
    assign arr_b       = b_q;
    assign done        = done_q;
    assign err_timeout = err_q;

endmodule
